// File: rtl/instruction_fetch_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_queue_pkg : shared types and constants for the fetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
package instruction_fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } pending_tag_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_queue_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : power-of-2 synchronous FIFO with clear and occupancy count
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter type T      = logic [31:0],
  parameter int  DEPTH  = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_DEPTH);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is honoured.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_queue : sequential imem fetch with epoch-tagged redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] C_LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_epoch;
  logic [CW-1:0] r_inflight;
  fetch_entry_t  r_last;

  pending_tag_t  w_tag_in;
  pending_tag_t  w_tag_out;
  fetch_entry_t  w_q_in;
  fetch_entry_t  w_q_head;
  logic          w_pend_full, w_pend_empty, w_q_full, w_q_empty;
  logic [CW-1:0] w_pend_count, w_q_count;
  logic          w_issue, w_pop, w_accept;
  logic [CW:0]   w_credit_used;
  logic [1:0]    w_unused;

  assign w_unused  = redirect_pc[1:0];
  assign w_pop     = out_valid && out_ready;
  // A slot being popped this cycle is already free, which sustains one fetch per cycle.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_q_count} - {{CW{1'b0}}, w_pop};
  assign imem_req  = !reset && !redirect_valid && (w_credit_used < C_LIMIT);
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_tag_in  = '{pc: r_fetch_pc, epoch: r_epoch};
  assign w_accept  = imem_rvalid && !redirect_valid && (w_tag_out.epoch == r_epoch);
  assign w_q_in    = '{pc: w_tag_out.pc, inst: imem_rdata};

  assign out_valid = !w_q_empty;
  assign out_pc    = w_q_empty ? r_last.pc   : w_q_head.pc;
  assign out_inst  = w_q_empty ? r_last.inst : w_q_head.inst;

  sync_fifo #(.T(pending_tag_t), .DEPTH(DEPTH)) u_pending (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .push      (w_issue),
    .push_data (w_tag_in),
    .pop       (imem_rvalid),
    .pop_data  (w_tag_out),
    .full      (w_pend_full),
    .empty     (w_pend_empty),
    .count     (w_pend_count)
  );

  sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (w_accept),
    .push_data (w_q_in),
    .pop       (w_pop),
    .pop_data  (w_q_head),
    .full      (w_q_full),
    .empty     (w_q_empty),
    .count     (w_q_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
      r_inflight <= '0;
      r_last     <= '{pc: RESET_PC, inst: NOP_INST};
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_epoch    <= ~r_epoch;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(imem_rvalid);
      // Remember what decode last saw so the outputs hold while empty.
      if (!w_q_empty) r_last <= w_q_head;
    end
  end

  a_rvalid_has_tag: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> !w_pend_empty);
  a_inflight_tracks_tags: assert property (@(posedge clock) disable iff (reset)
    r_inflight == w_pend_count);
  a_tags_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (w_issue && !imem_rvalid) |-> !w_pend_full);
  a_queue_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (w_accept && !w_pop) |-> !w_q_full);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instruction_fetch_queue : directed and randomised checks of the fetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_inst, out_pc;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  bit          gnt_on = 1'b0;
  bit          gnt_rand = 1'b0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] sb_pc;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: in-order responses, each due lat_min..lat_max cycles after issue.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_rvalid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
    end
  end

  always @(negedge clock) begin
    imem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : gnt_on;
    if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; gnt_on = 1'b0; gnt_rand = 1'b0; lat_min = 0; lat_max = 0;
    out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_inst !== NOP_INST) $display("FAIL reset_out_inst: got %h want %h", out_inst, NOP_INST); else n_pass++;
    n_checks++; if (out_pc !== RESET_PC) $display("FAIL reset_out_pc: got %h want %h", out_pc, RESET_PC); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL release_req: got %b want 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== RESET_PC) $display("FAIL release_addr: got %h want %h", imem_addr, RESET_PC); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = RESET_PC + 32'(4 * k);
      n_checks++; if (imem_req !== 1'b1) $display("FAIL seq_req[%0d]: got %b want 1", k, imem_req); else n_pass++;
      n_checks++; if (imem_addr !== exp) $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr, exp); else n_pass++;
      if (k < 2) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL seq_early_valid[%0d]: got %b want 0", k, out_valid); else n_pass++;
      end else begin
        exp = RESET_PC + 32'(4 * (k - 2));
        n_checks++; if (out_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
        n_checks++; if (out_pc !== exp) $display("FAIL seq_pc[%0d]: got %h want %h", k, out_pc, exp); else n_pass++;
        n_checks++; if (out_inst !== mem_word(exp)) $display("FAIL seq_inst[%0d]: got %h want %h", k, out_inst, mem_word(exp)); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++; if (imem_req !== (k < 2)) $display("FAIL bp_req[%0d]: got %b want %b", k, imem_req, (k < 2)); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", k, out_valid, out_pc, RESET_PC); else n_pass++;
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd8) $display("FAIL bp_resume_req: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC + 32'd8); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      exp = RESET_PC + 32'(4 * k);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== exp) $display("FAIL bp_drain[%0d]: got %b/%h want 1/%h", k, out_valid, out_pc, exp); else n_pass++;
      n_checks++; if (out_inst !== mem_word(exp)) $display("FAIL bp_inst[%0d]: got %h want %h", k, out_inst, mem_word(exp)); else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    int waited;
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b1; lat_min = 3; lat_max = 3;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rdi_req_in_redirect: got %b want 0", imem_req); else n_pass++;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0040_0100) $display("FAIL rdi_addr: got %h want 00400100", imem_addr); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rdi_stale_credit: got %b want 0", imem_req); else n_pass++;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rdi_timeout: got out_valid %b want 1 within 20 cycles", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 32'h0040_0100) $display("FAIL rdi_first_pc: got %h want 00400100", out_pc); else n_pass++;
    n_checks++; if (out_inst !== mem_word(32'h0040_0100)) $display("FAIL rdi_first_inst: got %h want %h", out_inst, mem_word(32'h0040_0100)); else n_pass++;
  endtask

  task automatic test_redirect_collision();
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0802;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'd4) $display("FAIL col_pop: got %b/%h want 1/%h", out_valid, out_pc, RESET_PC + 32'd4); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL col_req: got %b want 0", imem_req); else n_pass++;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL col_flush: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_pc !== RESET_PC + 32'd4) $display("FAIL col_hold_pc: got %h want %h", out_pc, RESET_PC + 32'd4); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0800) $display("FAIL col_restart: got %b/%h want 1/00400800", imem_req, imem_addr); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL col_gap: got %b want 0", out_valid); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0800) $display("FAIL col_first: got %b/%h want 1/00400800", out_valid, out_pc); else n_pass++;
    sb_pc = 32'h0040_0800;
  endtask

  task automatic test_random();
    int pops = 0;
    gnt_rand = 1'b1; lat_min = 0; lat_max = 5;
    for (int k = 0; k < 300; k++) begin
      out_ready      = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = RESET_PC + 32'($urandom_range(4095, 0));
      #1;
      if (out_valid && out_ready) begin
        n_checks++; if (out_pc !== sb_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", k, out_pc, sb_pc); else n_pass++;
        n_checks++; if (out_inst !== mem_word(sb_pc)) $display("FAIL rnd_inst[%0d]: got %h want %h", k, out_inst, mem_word(sb_pc)); else n_pass++;
        sb_pc = sb_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) sb_pc = {redirect_pc[31:2], 2'b00};
      tick();
    end
    redirect_valid = 1'b0;
    n_checks++; if (pops < 50) $display("FAIL rnd_progress: got %0d pops want >= 50", pops); else n_pass++;
  endtask

  task automatic test_no_leak();
    int pops = 0;
    gnt_rand = 1'b0; gnt_on = 1'b1; lat_min = 0; lat_max = 0;
    out_ready = 1'b0; redirect_valid = 1'b0;
    repeat (20) tick();
    n_checks++; if (imem_req !== 1'b0 || out_valid !== 1'b1) $display("FAIL leak_full: got req %b valid %b want 0/1", imem_req, out_valid); else n_pass++;
    gnt_on = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) begin
        n_checks++; if (out_pc !== sb_pc) $display("FAIL leak_pc[%0d]: got %h want %h", k, out_pc, sb_pc); else n_pass++;
        sb_pc = sb_pc + 32'd4;
        pops++;
      end
      tick();
    end
    n_checks++; if (pops != DEPTH) $display("FAIL leak_count: got %0d want %0d", pops, DEPTH); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b0;
    repeat (4) tick();
    n_checks++; if (out_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL mid_full: got valid %b req %b want 1/0", out_valid, imem_req); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL mid_reset: got valid %b req %b want 0/0", out_valid, imem_req); else n_pass++;
    n_checks++; if (out_pc !== RESET_PC || out_inst !== NOP_INST) $display("FAIL mid_reset_out: got %h/%h want %h/%h", out_pc, out_inst, RESET_PC, NOP_INST); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL mid_restart: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); else n_pass++;
    out_ready = 1'b1;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) $display("FAIL mid_first: got %b/%h want 1/%h", out_valid, out_pc, RESET_PC); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] base = 32'hFFFF_FFF8;
    logic [31:0] exp;
    do_reset();
    gnt_on = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k <= 3) begin
        exp = base + 32'(4 * (k - 1));
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp) $display("FAIL wrap_addr[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, exp); else n_pass++;
      end
      if (k >= 3) begin
        exp = base + 32'(4 * (k - 3));
        n_checks++; if (out_valid !== 1'b1 || out_pc !== exp) $display("FAIL wrap_out[%0d]: got %b/%h want 1/%h", k, out_valid, out_pc, exp); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_random();
    test_no_leak();
    test_reset_midstream();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
